pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Registered program-counter unit; parametrised successor of the combinational next-PC logic.
//  Holds CurrentPC and computes the next fetch address from unconditional, conditional
//  (ALUZero) and register (BR) branches. Advances under a valid/ready handshake with fetch, with stall.
//  Optional return-address stack (RAS) supplies return targets.
//  Sits between control/ALU outputs and the instruction-memory address port.
// PARAMETERS
//  ADDR_W     64  PC and target width in bits
//  IMM_SHIFT  2   left shift applied to SignExtImm before adding to CurrentPC
//  INST_BYTES 4   sequential increment
//  RESET_PC   0   CurrentPC value while in reset
//  RAS_DEPTH  4   RAS entries, power of 2, >=2 (used only with PC_RAS_EN)
// PORTS
//  CLK          in   1       clock, rising edge
//  Reset_L      in   1       asynchronous, active-low reset
//  FetchReady   in   1       fetch accepts CurrentPC this cycle
//  Stall        in   1       hold PC (hazard), overrides FetchReady
//  Uncondbranch in   1       B/BL: PC-relative always taken
//  Branch       in   1       CBZ-type: taken when ALUZero
//  ALUZero      in   1       ALU zero flag
//  RegBranch    in   1       BR: target = RegTarget
//  Link         in   1       BL: push return address (RAS)
//  Ret          in   1       RET: pop return address (RAS)
//  SignExtImm   in   ADDR_W  sign-extended word offset
//  RegTarget    in   ADDR_W  register branch target
//  CurrentPC    out  ADDR_W  registered fetch address
//  PCValid      out  1       CurrentPC is a valid fetch request
//  Taken        out  1       registered: last advance was a taken branch
//  AlignErr     out  1       registered 1-cycle pulse: RegTarget low bits nonzero
//  RasUnderflow out  1       registered 1-cycle pulse: Ret popped empty RAS
// BEHAVIOUR
//  Reset (async, Reset_L=0): CurrentPC=RESET_PC; PCValid, Taken, AlignErr, RasUnderflow=0; RAS empty.
//  First rising edge after Reset_L rises: PCValid<=1; PC unchanged. PCValid then stays 1.
//  Advance = PCValid & FetchReady & ~Stall; controls and operands sampled only on advance.
//  Without advance: all state holds; AlignErr/RasUnderflow/Taken clear to 0.
//  Next-PC priority on advance (1-cycle latency):
//   1 RegBranch|Ret -> RegTarget with low log2(INST_BYTES) bits forced 0; AlignErr<=1 if any nonzero
//   2 Uncondbranch   -> CurrentPC + (SignExtImm << IMM_SHIFT)
//   3 Branch&ALUZero -> CurrentPC + (SignExtImm << IMM_SHIFT)
//   4 otherwise      -> CurrentPC + INST_BYTES
//  Taken<=1 for cases 1-3, else 0. All sums modulo 2^ADDR_W (wrap, no flag).
//  Shift discards bits above ADDR_W; negative offsets wrap naturally.
//  Reset mid-operation: immediate return to reset values, pending branch discarded.
// CONFIGURATION
//  PC_RAS_EN defined: RAS_DEPTH-entry circular stack, pointer + count registers.
//   Link on advance pushes CurrentPC+INST_BYTES; full -> overwrite oldest, count saturates.
//   Ret on advance: count>0 -> pop, target = popped entry (overrides RegTarget, no AlignErr);
//   count==0 -> target from RegTarget, RasUnderflow<=1.
//   Link&Ret same cycle: pop first, then push (net replace top).
//  PC_RAS_EN undefined: no RAS storage; Link ignored; Ret identical to RegBranch;
//   RasUnderflow tied 0.
// STRUCTURE
//  Package pc_seq_pkg: next-PC source enum (SRC_REG, SRC_REL, SRC_SEQ, SRC_RAS), default widths.
//  One sub-module: pc_ras (stack storage, push/pop, count), instantiated only under PC_RAS_EN.
//  Next-PC mux and PC register in the top module.
// TESTING
//  Hold Reset_L=0, RESET_PC=0x1000 -> CurrentPC=0x1000, PCValid=0; release -> PCValid=1 next edge.
//  FetchReady=1, no branch, 3 cycles -> PC 0x1000,0x1004,0x1008,0x100C; Taken=0.
//  Branch=1, ALUZero=0 at 0x1008 -> 0x100C; ALUZero=1, SignExtImm=-2 -> 0x1000, Taken=1.
//  Stall=1 with Uncondbranch=1 for 2 cycles -> PC held; Stall=0 -> branch taken once.
//  PC=0xFFFF_FFFF_FFFF_FFFC sequential -> 0x0; RegTarget=0x2003 -> PC 0x2000, AlignErr pulse.
//  PC_RAS_EN, depth 4: 5 Links then 5 Rets -> last 4 return addresses LIFO, 5th RasUnderflow=1.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types for the program-counter sequencer: next-PC source encoding and default widths.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        SRC_REG = 2'd0,
        SRC_REL = 2'd1,
        SRC_SEQ = 2'd2,
        SRC_RAS = 2'd3
    } pc_src_e;

    localparam int unsigned DEF_ADDR_W     = 64;
    localparam int unsigned DEF_IMM_SHIFT  = 2;
    localparam int unsigned DEF_INST_BYTES = 4;
    localparam int unsigned DEF_RAS_DEPTH  = 4;

    function automatic logic src_taken(input pc_src_e src);
        return (src != SRC_SEQ);
    endfunction

endpackage

// File: rtl/pc_seq_if.sv
// Control/fetch bundle of the PC sequencer; slave = sequencer, master = control/fetch side.
interface pc_seq_if #(
    parameter int unsigned ADDR_W = pc_seq_pkg::DEF_ADDR_W
) ();
    logic              FetchReady;
    logic              Stall;
    logic              Uncondbranch;
    logic              Branch;
    logic              ALUZero;
    logic              RegBranch;
    logic              Link;
    logic              Ret;
    logic [ADDR_W-1:0] SignExtImm;
    logic [ADDR_W-1:0] RegTarget;
    logic [ADDR_W-1:0] CurrentPC;
    logic              PCValid;
    logic              Taken;
    logic              AlignErr;
    logic              RasUnderflow;

    modport master (
        output FetchReady, Stall, Uncondbranch, Branch, ALUZero, RegBranch, Link, Ret,
               SignExtImm, RegTarget,
        input  CurrentPC, PCValid, Taken, AlignErr, RasUnderflow
    );

    modport slave (
        input  FetchReady, Stall, Uncondbranch, Branch, ALUZero, RegBranch, Link, Ret,
               SignExtImm, RegTarget,
        output CurrentPC, PCValid, Taken, AlignErr, RasUnderflow
    );
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack; when full a push overwrites the oldest entry.
module pc_ras
    import pc_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DEPTH  = DEF_RAS_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [ADDR_W-1:0]        push_data_i,
    output logic [ADDR_W-1:0]        top_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  top_idx_s;

    assign top_idx_s = ptr_q - PTR_W'(1);
    assign top_o     = mem_q[top_idx_s];
    assign count_o   = count_q;

    // Pop-then-push in one cycle replaces the top entry in place.
    always_comb begin
        mem_d   = mem_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        if (pop_i && push_i) begin
            mem_d[top_idx_s] = push_data_i;
        end else if (pop_i) begin
            ptr_d   = top_idx_s;
            count_d = count_q - CNT_W'(1);
        end else if (push_i) begin
            mem_d[ptr_q] = push_data_i;
            ptr_d        = ptr_q + PTR_W'(1);
            count_d      = (count_q == CNT_W'(DEPTH)) ? count_q : count_q + CNT_W'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Stack storage and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q   <= '{default: '0};
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/pc_sequencer.sv
// Registered program counter with relative/conditional/register branches and fetch handshake.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned       ADDR_W     = DEF_ADDR_W,
    parameter int unsigned       IMM_SHIFT  = DEF_IMM_SHIFT,
    parameter int unsigned       INST_BYTES = DEF_INST_BYTES,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int unsigned       RAS_DEPTH  = DEF_RAS_DEPTH
) (
    input  logic     CLK,
    input  logic     Reset_L,
    pc_seq_if.slave  bus
);
    localparam int unsigned       CNT_W      = $clog2(RAS_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INST_BYTES - 1);
    localparam logic [ADDR_W-1:0] INST_INC   = ADDR_W'(INST_BYTES);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pc_valid_q, pc_valid_d;
    logic              taken_q, taken_d;
    logic              align_err_q, align_err_d;
    logic              ras_under_q, ras_under_d;

    logic              advance_s;
    pc_src_e           src_s;
    logic [ADDR_W-1:0] seq_pc_s, rel_pc_s, reg_pc_s, ras_top_s;
    logic [CNT_W-1:0]  ras_count_s;
    logic              ras_nonempty_s;
    logic              ras_on_s;

    assign advance_s      = pc_valid_q & bus.FetchReady & ~bus.Stall;
    assign seq_pc_s       = pc_q + INST_INC;
    assign rel_pc_s       = pc_q + (bus.SignExtImm << IMM_SHIFT);
    assign reg_pc_s       = bus.RegTarget & ~ALIGN_MASK;
    assign ras_nonempty_s = |ras_count_s;

`ifdef PC_RAS_EN
    assign ras_on_s = 1'b1;

    pc_ras #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk         (CLK),
        .rst_n       (Reset_L),
        .push_i      (advance_s & bus.Link),
        .pop_i       (advance_s & bus.Ret & ras_nonempty_s),
        .push_data_i (seq_pc_s),
        .top_o       (ras_top_s),
        .count_o     (ras_count_s)
    );
`else
    logic unused_link_s;

    assign ras_on_s      = 1'b0;
    assign ras_top_s     = '0;
    assign ras_count_s   = '0;
    assign unused_link_s = bus.Link;
`endif

    // Next-PC source priority: stack return, register branch, relative branch, sequential.
    always_comb begin
        src_s = SRC_SEQ;
        if (bus.Ret && ras_nonempty_s) begin
            src_s = SRC_RAS;
        end else if (bus.RegBranch || bus.Ret) begin
            src_s = SRC_REG;
        end else if (bus.Uncondbranch || (bus.Branch && bus.ALUZero)) begin
            src_s = SRC_REL;
        end else begin
            src_s = SRC_SEQ;
        end
    end

    // Next state; pulses and Taken drop to 0 on any cycle without an advance.
    always_comb begin
        pc_d        = pc_q;
        pc_valid_d  = 1'b1;
        taken_d     = 1'b0;
        align_err_d = 1'b0;
        ras_under_d = 1'b0;
        if (advance_s) begin
            case (src_s)
                SRC_RAS: pc_d = ras_top_s;
                SRC_REG: pc_d = reg_pc_s;
                SRC_REL: pc_d = rel_pc_s;
                SRC_SEQ: pc_d = seq_pc_s;
                default: pc_d = seq_pc_s;
            endcase
            taken_d     = src_taken(src_s);
            align_err_d = (src_s == SRC_REG) & (|(bus.RegTarget & ALIGN_MASK));
            ras_under_d = ras_on_s & bus.Ret & ~ras_nonempty_s;
        end else begin
            pc_d = pc_q;
        end
    end

    // PC and status registers.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            pc_q        <= RESET_PC;
            pc_valid_q  <= 1'b0;
            taken_q     <= 1'b0;
            align_err_q <= 1'b0;
            ras_under_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            pc_valid_q  <= pc_valid_d;
            taken_q     <= taken_d;
            align_err_q <= align_err_d;
            ras_under_q <= ras_under_d;
        end
    end

    assign bus.CurrentPC    = pc_q;
    assign bus.PCValid      = pc_valid_q;
    assign bus.Taken        = taken_q;
    assign bus.AlignErr     = align_err_q;
    assign bus.RasUnderflow = ras_under_q;
endmodule
